// File: rtl/fft_pkg.sv
// Shared widths and the round/saturate helper for the FFT twiddle-multiply datapath.
package fft_pkg;

  localparam int BFLY_W  = 10;
  localparam int TW_W    = 9;
  localparam int TW_FRAC = 7;
  localparam int ONE_Q   = 1 << TW_FRAC;

  typedef struct packed {
    logic [31:0] val;
    logic        sat;
  } rnd_t;

  // Round half up, drop frac bits, clamp to a signed out_w-bit range.
  function automatic rnd_t sat_round(input logic signed [63:0] sum, input int frac, input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd_t res;
    r  = (sum + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) begin
      res.val = hi[31:0];
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo[31:0];
      res.sat = 1'b1;
    end else begin
      res.val = r[31:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bfly_cmul_pipe_if.sv
// Vector handshake bundle between a butterfly stage, the twiddle multiplier and the next stage.
interface bfly_cmul_pipe_if
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int BFLY  = BFLY_W,
  parameter int TW    = TW_W,
  parameter int OUT_W = 11,
  parameter int TWL   = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_conj;
  logic                    in_bypass;
  logic signed [BFLY-1:0]  bfly_re [N];
  logic signed [BFLY-1:0]  bfly_im [N];
  logic signed [TW-1:0]    tw_re [TWL];
  logic signed [TW-1:0]    tw_im [TWL];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_re [N];
  logic signed [OUT_W-1:0] out_im [N];
  logic [N-1:0]            out_sat;

  modport master (
    output in_valid, in_conj, in_bypass, bfly_re, bfly_im, tw_re, tw_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat
  );

  modport slave (
    input  in_valid, in_conj, in_bypass, bfly_re, bfly_im, tw_re, tw_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat
  );
endinterface

// File: rtl/cmul_lane.sv
// One lane of the twiddle multiplier: capture, four products, combine/round/saturate.
module cmul_lane
  import fft_pkg::*;
#(
  parameter int BFLY  = BFLY_W,
  parameter int TW    = TW_W,
  parameter int FRAC  = 7,
  parameter int OUT_W = 11
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en1,
  input  logic                    en2,
  input  logic                    en3,
  input  logic                    conj,
  input  logic                    bypass,
  input  logic signed [BFLY-1:0]  bfly_re,
  input  logic signed [BFLY-1:0]  bfly_im,
  input  logic signed [TW-1:0]    tw_re,
  input  logic signed [TW-1:0]    tw_im,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    sat
);
  localparam int PW = BFLY + TW;
  localparam int SW = PW + 1;
  localparam logic signed [TW-1:0] ONE_W = TW'(1 << FRAC);

  logic signed [BFLY-1:0] pr_reg, pi_reg;
  logic signed [TW-1:0]   wr_reg, wi_reg;
  logic                   conj1_reg, conj2_reg;
  logic signed [PW-1:0]   p_rr_reg, p_ii_reg, p_ir_reg, p_ri_reg;
  logic signed [SW-1:0]   re_sum, im_sum;
  rnd_t                   re_rnd, im_rnd;
  logic                   unused_hi;

  // Conjugation flips the sign of the wi terms here rather than negating tw_im,
  // so the most negative twiddle value cannot overflow.
  always_comb begin
    re_sum = conj2_reg ? SW'(p_rr_reg) + SW'(p_ii_reg) : SW'(p_rr_reg) - SW'(p_ii_reg);
    im_sum = conj2_reg ? SW'(p_ir_reg) - SW'(p_ri_reg) : SW'(p_ir_reg) + SW'(p_ri_reg);
    re_rnd = sat_round(64'(re_sum), FRAC, OUT_W);
    im_rnd = sat_round(64'(im_sum), FRAC, OUT_W);
  end

  assign unused_hi = ^{re_rnd.val[31:OUT_W], im_rnd.val[31:OUT_W]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pr_reg    <= '0;
      pi_reg    <= '0;
      wr_reg    <= '0;
      wi_reg    <= '0;
      conj1_reg <= 1'b0;
      conj2_reg <= 1'b0;
      p_rr_reg  <= '0;
      p_ii_reg  <= '0;
      p_ir_reg  <= '0;
      p_ri_reg  <= '0;
      out_re    <= '0;
      out_im    <= '0;
      sat       <= 1'b0;
    end else begin
      if (en1) begin
        pr_reg    <= bfly_re;
        pi_reg    <= bfly_im;
        wr_reg    <= bypass ? ONE_W : tw_re;
        wi_reg    <= bypass ? '0 : tw_im;
        conj1_reg <= conj;
      end
      if (en2) begin
        p_rr_reg  <= PW'(pr_reg) * PW'(wr_reg);
        p_ii_reg  <= PW'(pi_reg) * PW'(wi_reg);
        p_ir_reg  <= PW'(pi_reg) * PW'(wr_reg);
        p_ri_reg  <= PW'(pr_reg) * PW'(wi_reg);
        conj2_reg <= conj1_reg;
      end
      if (en3) begin
        out_re <= re_rnd.val[OUT_W-1:0];
        out_im <= im_rnd.val[OUT_W-1:0];
        sat    <= re_rnd.sat | im_rnd.sat;
      end
    end
  end

endmodule

// File: rtl/bfly_cmul_pipe.sv
// N-lane pipelined butterfly x twiddle multiplier with a shared three-stage valid/ready controller.
module bfly_cmul_pipe #(
  parameter int BFLY        = fft_pkg::BFLY_W,
  parameter int TW          = fft_pkg::TW_W,
  parameter int TW_FRAC     = fft_pkg::TW_FRAC,
  parameter int OUT_W       = 11,
  parameter int N           = 16,
  parameter int TW_PER_LANE = 0
) (
  input logic            clk,
  input logic            rstn,
  bfly_cmul_pipe_if.slave bus
);
  logic v1_reg, v2_reg, v3_reg;
  logic adv1, adv2, adv3;
  logic sat_lane [N];

  // A stage moves when it is empty or the stage after it is moving.
  always_comb begin
    adv3 = !v3_reg || bus.out_ready;
    adv2 = !v2_reg || adv3;
    adv1 = !v1_reg || adv2;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      if (adv1) v1_reg <= bus.in_valid;
      if (adv2) v2_reg <= v1_reg;
      if (adv3) v3_reg <= v2_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam int TI = (TW_PER_LANE != 0) ? gi : 0;
      cmul_lane #(
        .BFLY  (BFLY),
        .TW    (TW),
        .FRAC  (TW_FRAC),
        .OUT_W (OUT_W)
      ) u_lane (
        .clk     (clk),
        .rstn    (rstn),
        .en1     (adv1 && bus.in_valid),
        .en2     (adv2 && v1_reg),
        .en3     (adv3 && v2_reg),
        .conj    (bus.in_conj),
        .bypass  (bus.in_bypass),
        .bfly_re (bus.bfly_re[gi]),
        .bfly_im (bus.bfly_im[gi]),
        .tw_re   (bus.tw_re[TI]),
        .tw_im   (bus.tw_im[TI]),
        .out_re  (bus.out_re[gi]),
        .out_im  (bus.out_im[gi]),
        .sat     (sat_lane[gi])
      );
      assign bus.out_sat[gi] = sat_lane[gi];
    end
  endgenerate

endmodule

// File: tb/tb_bfly_cmul_pipe.sv
// Directed bench for bfly_cmul_pipe: identity, rotation, conj, bypass, rounding, saturation, backpressure, reset.
module tb_bfly_cmul_pipe;
  import fft_pkg::*;

  localparam int N     = 16;
  localparam int BFLY  = BFLY_W;
  localparam int TW    = TW_W;
  localparam int OUT_W = 11;
  localparam int TWL   = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   acc, got, cyc;

  always #5 clk = ~clk;

  bfly_cmul_pipe_if #(.N(N), .BFLY(BFLY), .TW(TW), .OUT_W(OUT_W), .TWL(TWL)) bus ();

  bfly_cmul_pipe #(
    .BFLY(BFLY), .TW(TW), .TW_FRAC(TW_FRAC), .OUT_W(OUT_W), .N(N), .TW_PER_LANE(0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int br, input int bi, input int twr, input int twi, input logic conj, input logic byp);
    for (int k = 0; k < N; k++) begin
      bus.bfly_re[k] = BFLY'(br);
      bus.bfly_im[k] = BFLY'(bi);
    end
    for (int k = 0; k < TWL; k++) begin
      bus.tw_re[k] = TW'(twr);
      bus.tw_im[k] = TW'(twi);
    end
    bus.in_conj   = conj;
    bus.in_bypass = byp;
  endtask

  task automatic set_stream(input int i);
    for (int k = 0; k < N; k++) begin
      bus.bfly_re[k] = BFLY'(20 * i + k + 1);
      bus.bfly_im[k] = BFLY'(-(20 * i + k + 1));
    end
    bus.tw_re[0]  = TW'(ONE_Q);
    bus.tw_im[0]  = '0;
    bus.in_conj   = 1'b0;
    bus.in_bypass = 1'b0;
  endtask

  // Send one vector with out_ready high, then check latency and every lane of the result.
  task automatic run_one(input string tag, input int br, input int bi, input int twr, input int twi,
                         input logic conj, input logic byp, input int er, input int ei, input logic es);
    int lat;
    set_vec(br, bi, twr, twi, conj, byp);
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_re"}, bus.out_re[k], er);
      chk({tag, "_im"}, bus.out_im[k], ei);
    end
    chk({tag, "_sat"}, bus.out_sat, es ? {N{1'b1}} : '0);
    step();
    $display("txn %s: bfly=(%0d,%0d) tw=(%0d,%0d) conj=%0b byp=%0b -> (%0d,%0d) sat=%0h",
             tag, br, bi, twr, twi, conj, byp, bus.out_re[0], bus.out_im[0], bus.out_sat);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_vec(0, 0, 0, 0, 1'b0, 1'b0);
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_re", bus.out_re[0], 0);
    chk("rst_out_im", bus.out_im[N-1], 0);
    chk("rst_out_sat", bus.out_sat, 0);
    #20 rstn = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);

    run_one("identity", 100, -50, 128, 0, 1'b0, 1'b0, 100, -50, 1'b0);
    run_one("minus_j", 100, -50, 0, -128, 1'b0, 1'b0, -50, -100, 1'b0);
    run_one("conj", 100, -50, 0, -128, 1'b1, 1'b0, 50, 100, 1'b0);
    run_one("bypass", -512, 511, -256, -256, 1'b0, 1'b1, -512, 511, 1'b0);
    run_one("round_pos", 1, 0, 64, 0, 1'b0, 1'b0, 1, 0, 1'b0);
    run_one("round_neg", -1, 0, 64, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_one("saturate", 511, 511, 181, 181, 1'b0, 1'b0, 0, 1023, 1'b1);

    // Six vectors with the sink stalled for the first five cycles.
    acc = 0;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 40) begin
      bus.out_ready = (cyc >= 5);
      if (acc < 6) begin
        set_stream(acc);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 3 || cyc == 4) begin
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_accepted", acc, 3);
        chk("stall_hold_re", bus.out_re[0], 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("order_re", bus.out_re[0], 20 * got + 1);
        chk("order_im", bus.out_im[N-1], -(20 * got + N));
        $display("txn stream: vec=%0d re0=%0d imN=%0d", got, bus.out_re[0], bus.out_im[N-1]);
        got++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_received", got, 6);
    chk("stream_accepted", acc, 6);

    // Asynchronous reset while vectors are in flight.
    bus.out_ready = 1'b1;
    set_stream(0);
    bus.in_valid = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_valid", bus.out_valid, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_re", bus.out_re[0], 0);
    chk("mid_rst_sat", bus.out_sat, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    $display("txn reset: out_valid=%0b re0=%0d", bus.out_valid, bus.out_re[0]);
    bus.in_valid = 1'b0;
    #2 rstn = 1'b1;
    step();
    chk("after_rst_idle", bus.out_valid, 0);
    run_one("after_rst", 100, -50, 128, 0, 1'b0, 1'b0, 100, -50, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
